// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encodings are plain 2-bit constants so older code can compare against them directly.
package fetch_pkg;

  localparam int ADRS_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  localparam logic [7:0] ADRS_RST = 8'h00;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_ISSUE = 2'd2;

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: reads imem at the current PC, hands the word to decode,
// and advances the PC by +1 or redirects it on a branch.
//
// state   | meaning
// S_IDLE  | one cycle after reset, no request
// S_FETCH | requesting imem at pc_adrs until rdy (unless halted)
// S_ISSUE | instr held for decode until ack
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int ADRS_W  = ADRS_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADRS_W-1:0]  pc_adrs,
  output logic [ADRS_W-1:0]  nxt_adrs,
  output logic               en_pc,
  output logic               imem_req,
  output logic [ADRS_W-1:0]  imem_adrs,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  input  logic               instr_ack,
  input  logic               br_take,
  input  logic [ADRS_W-1:0]  br_target,
  input  logic               halt
);

  state_t state;
  logic   br_go;
  logic   fetch_done;

  // Branches are ignored in S_IDLE and while reset is asserted.
  assign br_go      = ~rst & br_take & (state != S_IDLE);
  assign imem_req   = ~rst & (state == S_FETCH) & ~halt & ~br_take;
  assign fetch_done = imem_req & imem_rdy;
  assign en_pc      = br_go | fetch_done;
  assign imem_adrs  = pc_adrs;

  always_comb begin
    nxt_adrs = pc_adrs;
    if (br_go)
      nxt_adrs = br_target;
    else if (fetch_done)
      nxt_adrs = pc_adrs + ADRS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      instr     <= '0;
      instr_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (fetch_done) begin
            instr     <= imem_data;
            instr_vld <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (br_go || instr_ack) begin
            instr_vld <= 1'b0;
            state     <= S_FETCH;
          end
        end
        default: begin
          instr_vld <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: PC register and memory modelled around the DUT, random and directed
// stimulus checked against a transaction-level model with an instruction scoreboard.
module tb_fetch_seq;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc_adrs = 8'h00;
  logic [7:0]  nxt_adrs;
  logic        en_pc;
  logic        imem_req;
  logic [7:0]  imem_adrs;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_vld;
  logic        instr_ack = 1'b0;
  logic        br_take = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        halt = 1'b0;

  logic [15:0] mem [256];
  logic [15:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  // model state: address the PC should hold, instruction outstanding, first cycle after reset
  logic [7:0] m_pc = 8'h00;
  logic       m_hold = 1'b0;
  logic       m_idle = 1'b1;

  always #5 clk = ~clk;

  fetch_seq #(.ADRS_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .pc_adrs(pc_adrs), .nxt_adrs(nxt_adrs), .en_pc(en_pc),
    .imem_req(imem_req), .imem_adrs(imem_adrs), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .instr(instr), .instr_vld(instr_vld), .instr_ack(instr_ack),
    .br_take(br_take), .br_target(br_target), .halt(halt)
  );

  always_ff @(posedge clk) begin
    if (rst)        pc_adrs <= ADRS_RST;
    else if (en_pc) pc_adrs <= nxt_adrs;
  end

  assign imem_data = mem[imem_adrs];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic h, input logic b, input logic [7:0] t,
                     input logic rd, input logic ak);
    logic       e_en, e_req, cap;
    logic [7:0] e_nxt;
    @(negedge clk);
    rst = r; halt = h; br_take = b; br_target = t; imem_rdy = rd; instr_ack = ak;
    #1;
    e_en = 1'b0; e_req = 1'b0; e_nxt = m_pc; cap = 1'b0;
    if (!r && !m_idle) begin
      if (b) begin
        e_en = 1'b1; e_nxt = t;
      end else if (!m_hold && !h) begin
        e_req = 1'b1;
        if (rd) begin
          e_en = 1'b1; e_nxt = m_pc + 8'd1; cap = 1'b1;
        end
      end
    end
    chk("en_pc", int'(en_pc), int'(e_en));
    chk("imem_req", int'(imem_req), int'(e_req));
    chk("nxt_adrs", int'(nxt_adrs), int'(e_nxt));
    chk("imem_adrs", int'(imem_adrs), int'(m_pc));
    #2;
    if (r) begin
      m_pc = ADRS_RST; m_hold = 1'b0; m_idle = 1'b1;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (b) begin
      m_pc = t; m_hold = 1'b0;
    end else if (m_hold) begin
      if (ak) m_hold = 1'b0;
    end else if (cap) begin
      exp_q.push_back(mem[m_pc]);
      m_pc = m_pc + 8'd1; m_hold = 1'b1;
    end
  endtask

  // monitor: instr_vld must track an outstanding expected word; accepted words are compared
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #2;
      chk("instr_vld", int'(instr_vld), int'(exp_q.size() != 0));
      if (instr_vld && (rst || br_take)) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (instr_vld && instr_ack) begin
        if (exp_q.size() == 0) begin
          chk("instr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("instr", int'(instr), int'(e));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(1, 0, 1, 8'h33, 1, 1);
    cyc(0, 0, 1, 8'h77, 1, 1);       // S_IDLE: branch ignored
    chk("instr_rst", int'(instr), 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 8'h00, 1, 1);
    // memory wait at address 05
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 1, 0);
    // decode backpressure
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 8'h00, 1, 1);
    // branch in S_FETCH at 10 with rdy high
    cyc(0, 0, 1, 8'h10, 0, 0);
    cyc(0, 0, 1, 8'h40, 1, 1);
    cyc(0, 0, 0, 8'h00, 1, 0);
    // branch in S_ISSUE with simultaneous ack
    cyc(0, 0, 1, 8'h80, 1, 1);
    cyc(0, 0, 0, 8'h00, 1, 1);
    // wrap at FF
    cyc(0, 0, 0, 8'h00, 1, 1);
    cyc(0, 0, 1, 8'hFF, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1, 1);
    // halt in S_FETCH, then release
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, 1, 1);
    cyc(0, 1, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 8'h00, 1, 0);
    cyc(0, 1, 0, 8'h00, 1, 0);       // halt in S_ISSUE has no effect
    // reset while an instruction is held
    cyc(0, 0, 0, 8'h00, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] t;
      t = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 14) == 0), t,
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
    end
    cyc(0, 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch sequencer that drives the program counter register and the instruction memory. It reads the current PC value, issues one instruction memory read per instruction, computes the next address (increment or branch redirect), and writes it back through the PC's load-enable port. Fetched instructions go to decode over a valid/ack handshake. It sits between the PC register, instruction memory and the decode stage.

## Interface
- ADRS_W, 8, address width; matches the PC register width.
- INSTR_W, 16, instruction word width.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_adrs  in  ADRS_W  current PC value, from the PC register output.
- nxt_adrs  out  ADRS_W  next PC value, to the PC register load input.
- en_pc  out  1  PC load enable; the PC loads nxt_adrs on the edge where this is 1.
- imem_req  out  1  instruction memory read request.
- imem_adrs  out  ADRS_W  read address; always equals pc_adrs.
- imem_rdy  in  1  memory has data on imem_data this cycle; only meaningful while imem_req=1.
- imem_data  in  INSTR_W  read data.
- instr  out  INSTR_W  fetched instruction, registered.
- instr_vld  out  1  instr holds a valid instruction, registered.
- instr_ack  in  1  decode consumes instr this cycle.
- br_take  in  1  branch redirect request, single-cycle pulse.
- br_target  in  ADRS_W  redirect address, valid while br_take=1.
- halt  in  1  suppress new fetch requests.

## Operation
- States:
  - S_IDLE: entered on reset. Moves unconditionally to S_FETCH on the next cycle. br_take is ignored in this state.
  - S_FETCH: imem_req = ~halt & ~br_take. When imem_req & imem_rdy:
    - capture imem_data into instr and set instr_vld=1;
    - drive en_pc=1 and nxt_adrs=pc_adrs+1;
    - go to S_ISSUE.
  - S_ISSUE: instr_vld=1 and instr is held stable. imem_req=0. When instr_ack=1: clear instr_vld and go to S_FETCH.
- Increment is modulo 2^ADRS_W: 8'hFF increments to 8'h00, with no flag.
- Branch (br_take=1, state S_FETCH or S_ISSUE) has priority over everything except rst:
  - en_pc=1 and nxt_adrs=br_target in that cycle;
  - imem_req is forced to 0, so an imem_rdy in that cycle is ignored;
  - instr_vld clears on the next edge, and a simultaneous instr_ack has no effect;
  - next state is S_FETCH.
- halt=1 in S_FETCH: no request, state holds, and en_pc=0 unless br_take=1.
- halt has no effect in S_ISSUE; the held instruction still completes its handshake.
- Outside a completed fetch or a branch, en_pc=0 and nxt_adrs=pc_adrs.
- rst=1 is sampled at the edge and overrides all inputs. While rst=1, en_pc and imem_req are forced to 0 combinationally.
- The PC register is reset by the same system reset, so the first fetch reads address 8'h00.

## Timing
- Reset values: state=S_IDLE, instr=0, instr_vld=0, imem_req=0, en_pc=0, nxt_adrs=pc_adrs.
- Combinational outputs: en_pc, nxt_adrs, imem_req, imem_adrs (from state and inputs). Registered outputs: instr, instr_vld.
- Fetch latency: instr_vld rises on the edge ending the imem_rdy cycle.
- pc_adrs shows the new value one cycle after en_pc=1.
- Best-case throughput is one instruction per 2 cycles (rdy in the first S_FETCH cycle, ack in the first S_ISSUE cycle).
- Memory may hold imem_rdy low for any number of cycles. imem_req stays high and imem_adrs stays stable until rdy, halt or br_take.
- instr_vld is never lowered without an ack, except on br_take or rst.

## Structure
- Package fetch_pkg holds:
  - the state typedef (S_IDLE, S_FETCH, S_ISSUE, 2-bit encoding);
  - default ADRS_W and INSTR_W;
  - the ADRS_RST constant 8'h00.
- Single module; no sub-module needed. The +1 incrementer and the redirect mux are inline.
- Instantiated at top level beside the PC register: nxt_adrs→PC load input, en_pc→PC enable, PC output→pc_adrs.

## Test plan
- Reset then free run, with rdy and ack always high: imem_adrs sequence 00,01,02,… One instr_vld pulse every 2 cycles, with instr equal to imem_data of the matching address.
- Memory wait: hold imem_rdy low 3 cycles at address 05 → imem_req high for 4 cycles with imem_adrs=05, en_pc=1 only in the 4th, then pc_adrs=06.
- Decode backpressure: instr_ack low 5 cycles → instr_vld stays 1, instr unchanged, imem_req=0, en_pc=0 throughout.
- Branch in S_FETCH at PC=10 with br_target=40, imem_rdy=1 in the same cycle → no capture, en_pc=1 with nxt_adrs=40, next request at 40.
- Branch in S_ISSUE with instr_ack=1 in the same cycle → instr_vld cleared, PC=target, next fetch from target.
- Wrap and control: fetch at FF gives nxt_adrs=00. halt=1 in S_FETCH gives imem_req=0 and PC frozen. rst asserted in S_ISSUE gives S_IDLE and instr_vld=0 next cycle, then fetch resumes from 00.
